// File: rtl/cpa_seg_resolver.sv
// cpa_seg_resolver
// Multi-cycle carry-propagate adder that resolves a carry-save pair into a
// binary result, SEG bits per cycle, with valid/ready handshakes on both sides.
//
// Parameters:
//   WIDTH - operand/result width (>= 2, multiple of SEG)
//   SEG   - bits resolved per cycle (1..WIDTH)
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - operand handshake (sum, carry)
//   sum, carry         - carry-save pair; carry bit i weighs 2^(i+1)
//   out_valid/out_ready- result handshake
//   result             - (sum + (carry << 1)) mod 2^WIDTH
//   cout               - unsigned carry out of the WIDTH-bit add
//   ovf                - two's-complement overflow of the WIDTH-bit add
module cpa_seg_resolver #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    seg_idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;

  logic [SEG-1:0]   a_seg;
  logic [SEG-1:0]   b_seg;
  logic [SEG-1:0]   r_seg;
  logic             c_next;
  logic             last_seg;
  logic             accept;

  // carry[WIDTH-1] would weigh 2^WIDTH and falls outside the result.
  logic             carry_msb_unused;
  assign carry_msb_unused = carry[WIDTH-1];

  // in_ready never looks at in_valid, so no combinational loop with the sender.
  assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign result    = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  assign last_seg  = (seg_idx == IW'(NSEG - 1));

  always_comb begin
    a_seg = a_q[SEG*int'(seg_idx) +: SEG];
    b_seg = b_q[SEG*int'(seg_idx) +: SEG];
    {c_next, r_seg} = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      seg_idx <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q     <= sum;
            b_q     <= {carry[WIDTH-2:0], 1'b0};
            seg_idx <= '0;
            c_q     <= 1'b0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          res_q[SEG*int'(seg_idx) +: SEG] <= r_seg;
          c_q <= c_next;
          if (last_seg) begin
            seg_idx <= '0;
            cout_q  <= c_next;
            // r_seg MSB is the final result MSB on the last segment.
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_seg[SEG-1] != a_q[WIDTH-1]);
            state   <= S_DONE;
          end else begin
            seg_idx <= seg_idx + 1'b1;
          end
        end
        S_DONE: begin
          // Transfer and a new accept may share one edge.
          if (accept) begin
            a_q     <= sum;
            b_q     <= {carry[WIDTH-2:0], 1'b0};
            seg_idx <= '0;
            c_q     <= 1'b0;
            state   <= S_BUSY;
          end else if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
